alu_pipe: RTL

//   Parametrised, registered RISC ALU with a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    StIdle,
    StMul
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, mcand_q, step_sum;
  logic [WIDTH-1:0]   mplr_q;
  logic [CntW-1:0]    cnt_q;
  logic               run_q;

  assign step_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
  // done is high in the cycle whose closing edge performs the final step
  assign done     = run_q && (cnt_q == CntW'(WIDTH - 1));
  assign product  = step_sum;

  // Operand load on start, then one shift-add step per cycle until done.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      acc_q   <= '0;
      mcand_q <= {{WIDTH{1'b0}}, a};
      mplr_q  <= b;
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      acc_q   <= step_sum;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + CntW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered RISC ALU with valid/ready handshakes and an iterative multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MUL_EN     = 1,
  parameter int unsigned SIGNED_SLT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned ShW = $clog2(WIDTH);

  alu_state_e state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             zero_q, zero_d, carry_q, carry_d, overflow_q, overflow_d;

  logic               accept, is_mul, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     add_full, sub_full;
  logic [ShW-1:0]     shamt;
  logic               lt;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v;

  assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (alu_control == ALU_MUL) && (MUL_EN != 0);
  assign mul_start = accept && is_mul;

  assign add_full = {1'b0, ra} + {1'b0, rb};
  assign sub_full = {1'b0, ra} + {1'b0, ~rb} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt    = rb[ShW-1:0];
  assign lt       = (SIGNED_SLT != 0) ? ($signed(ra) < $signed(rb)) : (ra < rb);

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (ra),
    .b      (rb),
    .done   (mul_done),
    .product(mul_prod)
  );

  // Single-cycle result and flags; MUL (or disabled MUL) falls to the zero default.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (alu_control)
      ALU_AND: res = ra & rb;
      ALU_OR:  res = ra | rb;
      ALU_ADD: begin
        res   = add_full[WIDTH-1:0];
        res_c = add_full[WIDTH];
        res_v = (ra[WIDTH-1] == rb[WIDTH-1]) && (add_full[WIDTH-1] != ra[WIDTH-1]);
      end
      ALU_SLL: res = ra << shamt;
      ALU_SRL: res = ra >> shamt;
      ALU_SUB: begin
        res   = sub_full[WIDTH-1:0];
        // no carry-out of ra + ~rb + 1 means a borrow occurred
        res_c = ~sub_full[WIDTH];
        res_v = (ra[WIDTH-1] != rb[WIDTH-1]) && (sub_full[WIDTH-1] != ra[WIDTH-1]);
      end
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      default: res = '0;
    endcase
  end

  // Handshake FSM and output register next-state.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    rd_d        = rd_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d     = StMul;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            rd_d        = res;
            zero_d      = (res == '0);
            carry_d     = res_c;
            overflow_d  = res_v;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          rd_d        = mul_prod[WIDTH-1:0];
          zero_d      = (mul_prod[WIDTH-1:0] == '0);
          carry_d     = |mul_prod[2*WIDTH-1:WIDTH];
          overflow_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == StMul);

endmodule
